// File: rtl/spu_mem_pkg.sv
// Shared types and sizing for the SPU memory-access stage.
package spu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } ls_state_e;

  localparam int QW_BITS            = 128;
  localparam int RT_BITS            = 7;
  localparam int LS_AW_DEFAULT      = 11;
  localparam int LS_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/mem_access_stage_if.sv
// Local-store request/grant/read-valid bus between the memory stage (master) and LS (slave).
interface mem_access_stage_if #(
  parameter int LS_AW = spu_mem_pkg::LS_AW_DEFAULT
);
  logic                            req;
  logic                            we;
  logic [LS_AW-1:0]                addr;
  logic [spu_mem_pkg::QW_BITS-1:0] wdata;
  logic                            gnt;
  logic                            rvalid;
  logic [spu_mem_pkg::QW_BITS-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ls_timeout_ctr.sv
// Counts cycles an LS access has been outstanding; flags expiry on the LIMIT-th cycle.
module ls_timeout_ctr #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_r;

  // Saturating cycle counter, cleared while the stage is idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable && (cnt_r != W'(LIMIT))) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = enable && (cnt_r >= W'(LIMIT - 1));
endmodule

// File: rtl/mem_access_stage.sv
// SPU memory stage: issues quadword LS loads/stores and stalls the pipe while one is outstanding.
// Optional MEM_STALL_CNT_EN adds a saturating stalled-cycle counter on stall_cycles_out.
module mem_access_stage
  import spu_mem_pkg::*;
#(
  parameter int LS_AW      = LS_AW_DEFAULT,
  parameter int LS_TIMEOUT = LS_TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  input  logic               mem_read_in,
  input  logic               mem_write_in,
  input  logic               mem_to_reg_in,
  input  logic               regWrite_enable_in,
  input  logic [QW_BITS-1:0] ALUResult_in,
  input  logic [QW_BITS-1:0] storeData_in,
  input  logic [RT_BITS-1:0] RegisterRT_in,
  output logic               mem_to_reg_out,
  output logic               regWrite_enable_out,
  output logic [QW_BITS-1:0] readData_out,
  output logic [QW_BITS-1:0] ALUResult_out,
  output logic [RT_BITS-1:0] RegisterRT_out,
  output logic               stall_out,
  output logic               err_out,
`ifdef MEM_STALL_CNT_EN
  output logic [31:0]        stall_cycles_out,
`endif
  mem_access_stage_if.master ls
);

  ls_state_e          state_r;
  ls_state_e          state_nxt_s;
  logic               mem_op_s;
  logic               stall_s;
  logic               abort_s;
  logic               expired_s;
  logic               err_r;
  logic [QW_BITS-1:0] read_data_r;

  assign mem_op_s = valid_in && (mem_read_in || mem_write_in);

  ls_timeout_ctr #(.LIMIT(LS_TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_r == IDLE),
    .enable  ((state_r == REQ) || (state_r == WAIT)),
    .expired (expired_s)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, stall and abort decode; a grant/rvalid on the expiry cycle still completes
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_op_s) begin
          state_nxt_s = REQ;
          stall_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        stall_s = 1'b1;
        if (ls.gnt) begin
          state_nxt_s = mem_write_in ? DONE : WAIT;
        end else if (expired_s) begin
          state_nxt_s = DONE;
          abort_s     = 1'b1;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        stall_s = 1'b1;
        if (ls.rvalid) begin
          state_nxt_s = DONE;
        end else if (expired_s) begin
          state_nxt_s = DONE;
          abort_s     = 1'b1;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Load-data capture and one-cycle error flag (high exactly during an aborted DONE)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data_r <= '0;
      err_r       <= 1'b0;
    end else begin
      err_r <= abort_s;
      if (abort_s) begin
        read_data_r <= '0;
      end else if ((state_r == WAIT) && ls.rvalid) begin
        read_data_r <= ls.rdata;
      end else begin
        read_data_r <= read_data_r;
      end
    end
  end

`ifdef MEM_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= 32'h0000_0000;
    end else if (stall_out && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cycles_out = stall_cnt_r;
`endif

  // stall is gated by reset so an asserted reset releases the pipe immediately
  assign stall_out           = reset && stall_s;
  assign err_out             = err_r;
  assign readData_out        = read_data_r;
  assign mem_to_reg_out      = mem_to_reg_in;
  assign ALUResult_out       = ALUResult_in;
  assign RegisterRT_out      = RegisterRT_in;
  assign regWrite_enable_out = regWrite_enable_in && valid_in && !stall_s && !err_r;

  assign ls.req   = (state_r == REQ);
  assign ls.we    = (state_r == REQ) && mem_write_in;
  assign ls.addr  = ALUResult_in[LS_AW+99:100];
  assign ls.wdata = storeData_in;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: pass-through vectors plus load/store/timeout/reset sequences.
module tb_mem_access_stage;

  logic         clk;
  logic         reset;
  logic         valid_in, mem_read_in, mem_write_in, mem_to_reg_in, regWrite_enable_in;
  logic [127:0] ALUResult_in, storeData_in;
  logic [6:0]   RegisterRT_in;
  logic         mem_to_reg_out, regWrite_enable_out;
  logic [127:0] readData_out, ALUResult_out;
  logic [6:0]   RegisterRT_out;
  logic         stall_out, err_out;
`ifdef MEM_STALL_CNT_EN
  logic [31:0]  stall_cycles_out;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_stage_if #(.LS_AW(11)) lsif ();

  mem_access_stage dut (
    .clk                 (clk),
    .reset               (reset),
    .valid_in            (valid_in),
    .mem_read_in         (mem_read_in),
    .mem_write_in        (mem_write_in),
    .mem_to_reg_in       (mem_to_reg_in),
    .regWrite_enable_in  (regWrite_enable_in),
    .ALUResult_in        (ALUResult_in),
    .storeData_in        (storeData_in),
    .RegisterRT_in       (RegisterRT_in),
    .mem_to_reg_out      (mem_to_reg_out),
    .regWrite_enable_out (regWrite_enable_out),
    .readData_out        (readData_out),
    .ALUResult_out       (ALUResult_out),
    .RegisterRT_out      (RegisterRT_out),
    .stall_out           (stall_out),
    .err_out             (err_out),
`ifdef MEM_STALL_CNT_EN
    .stall_cycles_out    (stall_cycles_out),
`endif
    .ls                  (lsif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         valid, rd, wr, mtr, rwe;
    logic [127:0] alu;
    logic [6:0]   rt;
    logic         exp_rwe;
  } vec_t;

  vec_t vecs [4];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_pipe(input logic v, input logic rd, input logic wr, input logic mtr,
                          input logic rwe, input logic [127:0] alu, input logic [127:0] sd,
                          input logic [6:0] rt);
    valid_in = v; mem_read_in = rd; mem_write_in = wr; mem_to_reg_in = mtr;
    regWrite_enable_in = rwe; ALUResult_in = alu; storeData_in = sd; RegisterRT_in = rt;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Acts as LS for one access; returns at the first unstalled (DONE) cycle, mid-cycle
  task automatic do_access(input int gnt_dly, input bit give_rv, input logic [127:0] rv_data,
                           input logic [10:0] exp_addr, input logic exp_we,
                           output int stalls, output int reqs);
    bit done = 1'b0;
    bit rv_next = 1'b0;
    stalls = 0;
    reqs   = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      lsif.rvalid = rv_next;
      lsif.rdata  = rv_next ? rv_data : 128'h0;
      rv_next     = 1'b0;
      if (lsif.req) begin
        lsif.gnt = (reqs == gnt_dly);
        if (lsif.gnt && give_rv && !exp_we) rv_next = 1'b1;
        reqs++;
      end else begin
        lsif.gnt = 1'b0;
      end
      @(negedge clk);
      if (lsif.req) begin
        chkv("ls_addr", 128'(lsif.addr), 128'(exp_addr));
        chk1("ls_we", lsif.we, exp_we);
        chkv("ls_wdata", lsif.wdata, storeData_in);
      end
      if (stall_out) stalls++;
      else done = 1'b1;
      if (!done) next_cycle();
    end
    lsif.gnt    = 1'b0;
    lsif.rvalid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL access_timeout: stall still %b after 200 cycles, required 0", stall_out);
    end
  endtask

  int stalls, reqs;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, {32'hDEAD_BEEF, 96'h1}, 7'd3, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {128{1'b1}}, 7'd127, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 7'd64, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 128'h0, 7'd0, 1'b1};

    reset = 1'b0;
    set_pipe(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 128'h0, 128'h0, 7'd0);
    lsif.gnt = 1'b0; lsif.rvalid = 1'b0; lsif.rdata = 128'h0;
    #12;
    chk1("rst_stall", stall_out, 1'b0);
    chk1("rst_req", lsif.req, 1'b0);
    chk1("rst_we", lsif.we, 1'b0);
    chk1("rst_err", err_out, 1'b0);
    chkv("rst_rdata", readData_out, 128'h0);
    reset = 1'b1;
    next_cycle();

    // Pass-through vectors, FSM stays idle (vector 2 is a load bubble)
    for (int i = 0; i < 4; i++) begin
      set_pipe(vecs[i].valid, vecs[i].rd, vecs[i].wr, vecs[i].mtr, vecs[i].rwe,
               vecs[i].alu, 128'h5, vecs[i].rt);
      @(negedge clk);
      chkv("pt_alu", ALUResult_out, vecs[i].alu);
      chkv("pt_rt", 128'(RegisterRT_out), 128'(vecs[i].rt));
      chk1("pt_mtr", mem_to_reg_out, vecs[i].mtr);
      chk1("pt_rwe", regWrite_enable_out, vecs[i].exp_rwe);
      chk1("pt_stall", stall_out, 1'b0);
      chk1("pt_req", lsif.req, 1'b0);
      next_cycle();
    end

    // Load 0x120: gnt at once, rvalid next cycle
    set_pipe(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, {32'h0000_0120, 96'h0}, 128'h0, 7'd5);
    do_access(0, 1'b1, 128'hCAFE_0000_1111_2222_3333_4444_5555_6666, 11'd18, 1'b0, stalls, reqs);
    chkv("ld_stalls", 128'(stalls), 128'd3);
    chkv("ld_reqs", 128'(reqs), 128'd1);
    chkv("ld_rdata", readData_out, 128'hCAFE_0000_1111_2222_3333_4444_5555_6666);
    chk1("ld_rwe", regWrite_enable_out, 1'b1);
    chkv("ld_rt", 128'(RegisterRT_out), 128'd5);
    chk1("ld_err", err_out, 1'b0);
    next_cycle();
    set_pipe(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 128'h0, 128'h0, 7'd0);

    // Store 0x40: grant delayed 5 cycles
    set_pipe(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, {32'h0000_0040, 96'h0},
             128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0, 7'd9);
    do_access(5, 1'b0, 128'h0, 11'd4, 1'b1, stalls, reqs);
    chkv("st_stalls", 128'(stalls), 128'd7);
    chkv("st_reqs", 128'(reqs), 128'd6);
    chk1("st_rwe", regWrite_enable_out, 1'b0);
    chk1("st_err", err_out, 1'b0);
`ifdef MEM_STALL_CNT_EN
    chkv("stall_cnt", 128'(stall_cycles_out), 128'd10);
`endif
    next_cycle();
    set_pipe(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 128'h0, 128'h0, 7'd0);

    // Load granted but never answered: abort after the timeout window
    set_pipe(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, {32'h0000_0200, 96'h0}, 128'h0, 7'd7);
    do_access(0, 1'b0, 128'h0, 11'd32, 1'b0, stalls, reqs);
    chkv("to_stalls", 128'(stalls), 128'd65);
    chk1("to_err", err_out, 1'b1);
    chk1("to_rwe", regWrite_enable_out, 1'b0);
    chkv("to_rdata", readData_out, 128'h0);
    next_cycle();
    set_pipe(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 128'h0, 128'h0, 7'd0);
    @(negedge clk);
    chk1("to_err_pulse", err_out, 1'b0);
    next_cycle();

    // Reset asserted while waiting on read data, then a clean load
    set_pipe(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, {32'h0000_0030, 96'h0}, 128'h0, 7'd11);
    lsif.gnt = 1'b1;
    next_cycle();
    next_cycle();
    lsif.gnt = 1'b0;
    @(negedge clk);
    chk1("rw_wait_stall", stall_out, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk1("rw_stall", stall_out, 1'b0);
    chk1("rw_req", lsif.req, 1'b0);
    next_cycle();
    reset = 1'b1;
    do_access(0, 1'b1, 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE, 11'd3, 1'b0, stalls, reqs);
    chkv("rw_ld_stalls", 128'(stalls), 128'd3);
    chkv("rw_ld_rdata", readData_out, 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE);
    chk1("rw_ld_rwe", regWrite_enable_out, 1'b1);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
